ibox_issue: RTL
===============

// Module: ibox_issue
// PURPOSE
//  Issue stage directly upstream of the integer execute box. Decodes a 32-bit Alpha
//  instruction, reads and bypasses source registers, and applies the literal or
//  displacement. Presents {a, b, opcode[12:0]} plus destination info through one
//  registered valid/ready stage. A load scoreboard holds dependent instructions.
// PARAMETERS
//  BYPASS      1  1: forward wb_data to a same-cycle read of wb_addr; 0: register-file data only
//  SCOREBOARD  1  1: track in-flight load destinations and stall dependants; 0: never stall
// PORTS
//  clk          in   1   clock; all state updates on the rising edge
//  reset_n      in   1   synchronous active-low reset
//  flush        in   1   discard the output-stage instruction and the input beat
//  in_valid     in   1   instruction beat valid
//  in_ready     out  1   stage can accept the instruction this cycle
//  in_inst      in   32  Alpha instruction word
//  rf_raddr_a   out  5   register-file read address A (combinational from in_inst[25:21])
//  rf_raddr_b   out  5   register-file read address B (combinational from in_inst[20:16])
//  rf_rdata_a   in   64  combinational read data A
//  rf_rdata_b   in   64  combinational read data B
//  wb_en        in   1   writeback this cycle
//  wb_addr      in   5   writeback register
//  wb_data      in   64  writeback data
//  wb_load      in   1   writeback is a load return; clears that register's scoreboard bit
//  out_valid    out  1   issue-register contents valid
//  out_ready    in   1   execute stage accepts this cycle
//  out_a        out  64  execute operand a
//  out_b        out  64  execute operand b
//  out_opcode   out  13  {inst[31:26], func7}; func7 = 0 for memory format
//  out_st_data  out  64  Ra value for stores; otherwise 0
//  out_dest     out  5   destination register; 31 = no write
//  out_illegal  out  1   opcode not in the supported set; instruction still flows
// BEHAVIOUR
//  - Reset: out_valid=0; all other out_*=0; scoreboard=0. in_ready follows the rules below.
//  - Register 31 always reads 0: no bypass and no scoreboard for r31.
//  - Read value: if BYPASS, wb_en, and wb_addr==addr!=31, use wb_data; else use rf_rdata.
//  - Operate format (op 0x10-0x13):
//      a = Ra; b = inst[12] ? {56'b0, inst[20:13]} : Rb; func7 = inst[11:5];
//      dest = inst[4:0]. Rb is a source only when inst[12]=0.
//  - Memory format (0x08-0x0F, 0x28-0x2F):
//      a = sext64(inst[15:0]); b = Rb; dest = Ra for LDA/LDAH/loads, 31 for stores.
//      Stores: out_st_data = Ra, and Ra is a source.
//  - Any other opcode: out_illegal=1, a=b=0, dest=31, no sources.
//  - Hazard: SCOREBOARD=1 and a source's pending bit set, unless cleared this cycle
//      (wb_en & wb_load & wb_addr==src) with BYPASS=1.
//  - in_ready = !hazard & (!out_valid | out_ready).
//  - Accept: in_valid & in_ready & !flush. Latency 1: outputs update on the next edge.
//  - Output hold: out_* held stable while out_valid & !out_ready.
//  - Output update: out_valid <= accept | (out_valid & !out_ready & !flush).
//  - Scoreboard set: on accept of a load (0x0A-0x0C, 0x28-0x2B) with dest!=31.
//  - Scoreboard clear: on wb_en & wb_load. If set and clear hit the same register
//      in one cycle, set wins.
//  - flush: clears out_valid next edge; scoreboard untouched (loads still in flight).
//  - Mid-operation reset behaves identically to power-up reset.
// STRUCTURE
//  Shared package ibox_pkg:
//    opcode localparams (OP_LDA ... OP_MUL), FMT_MEM/FMT_OPR enum, REG_ZERO=5'd31,
//    is_load/is_store functions.
//  One sub-module ibox_decode (combinational): sources, dest, format, literal select, illegal.
//  Issue register, bypass and scoreboard stay in ibox_issue.
// TESTING
//  1. ADDQ r1,r2,r3 with rf r1=5, r2=7, out_ready=1:
//     next cycle out_a=5, out_b=7, out_opcode=13'h820, out_dest=3.
//  2. Operate literal inst[12]=1, lit=0xFF: out_b=64'hFF; rf_raddr_b ignored.
//     LDAH disp 0x8000: out_a=64'hFFFF_FFFF_FFFF_8000.
//  3. LDQ r4 then ADDQ r4,r1,r5: ADDQ stalls (in_ready=0) until wb_en & wb_load & wb_addr=4;
//     that cycle it accepts with out_a=wb_data.
//  4. out_ready=0 for 3 cycles: out_* stable and in_ready=0.
//     Release: the next instruction issues with no loss or duplication.
//  5. flush while out_valid=1 and pending load r4: out_valid=0 next cycle; r4 still blocks.
//     r31 source never stalls and reads 0.
//  6. Reset mid-stall: scoreboard cleared, out_valid=0; opcode 0x01 issues with out_illegal=1.

Source files
------------

// File: rtl/ibox_pkg.sv
// Shared definitions for the integer issue stage: opcodes, formats, decode payload.
package ibox_pkg;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned REG_W = 5;
    localparam int unsigned OPC_W = 13;

    localparam logic [5:0] OP_LDA   = 6'h08;
    localparam logic [5:0] OP_LDAH  = 6'h09;
    localparam logic [5:0] OP_LDBU  = 6'h0A;
    localparam logic [5:0] OP_LDQ_U = 6'h0B;
    localparam logic [5:0] OP_LDWU  = 6'h0C;
    localparam logic [5:0] OP_STW   = 6'h0D;
    localparam logic [5:0] OP_STB   = 6'h0E;
    localparam logic [5:0] OP_STQ_U = 6'h0F;
    localparam logic [5:0] OP_INTA  = 6'h10;
    localparam logic [5:0] OP_INTL  = 6'h11;
    localparam logic [5:0] OP_INTS  = 6'h12;
    localparam logic [5:0] OP_MUL   = 6'h13;
    localparam logic [5:0] OP_LDL   = 6'h28;
    localparam logic [5:0] OP_LDQ   = 6'h29;
    localparam logic [5:0] OP_LDL_L = 6'h2A;
    localparam logic [5:0] OP_LDQ_L = 6'h2B;
    localparam logic [5:0] OP_STL   = 6'h2C;
    localparam logic [5:0] OP_STQ   = 6'h2D;
    localparam logic [5:0] OP_STL_C = 6'h2E;
    localparam logic [5:0] OP_STQ_C = 6'h2F;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd31;

    typedef enum logic [1:0] {
        FMT_MEM = 2'd0,
        FMT_OPR = 2'd1,
        FMT_ILL = 2'd2
    } fmt_e;

    // Decoded control for one instruction word
    typedef struct packed {
        fmt_e             fmt;
        logic             use_a;
        logic             use_b;
        logic             use_lit;
        logic             load;
        logic             store;
        logic             illegal;
        logic [REG_W-1:0] dest;
        logic [6:0]       func7;
    } dec_t;

    function automatic logic is_load(input logic [5:0] op);
        case (op)
            OP_LDBU, OP_LDQ_U, OP_LDWU,
            OP_LDL, OP_LDQ, OP_LDL_L, OP_LDQ_L: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        case (op)
            OP_STW, OP_STB, OP_STQ_U,
            OP_STL, OP_STQ, OP_STL_C, OP_STQ_C: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ibox_decode.sv
// Combinational instruction decode: format, sources, destination, literal select.
module ibox_decode
    import ibox_pkg::*;
(
    input  logic [5:0]       op,
    input  logic [REG_W-1:0] ra,
    input  logic             lit_sel,
    input  logic [6:0]       func,
    input  logic [REG_W-1:0] rc,
    output dec_t             dec
);

    // Classify the opcode and derive operand usage
    always_comb begin
        dec      = '0;
        dec.fmt  = FMT_ILL;
        dec.dest = REG_ZERO;
        if (op inside {[OP_INTA:OP_MUL]}) begin
            dec.fmt     = FMT_OPR;
            dec.use_a   = 1'b1;
            dec.use_lit = lit_sel;
            dec.use_b   = !lit_sel;
            dec.func7   = func;
            dec.dest    = rc;
        end else if (op inside {[OP_LDA:OP_STQ_U], [OP_LDL:OP_STQ_C]}) begin
            dec.fmt   = FMT_MEM;
            dec.use_b = 1'b1;
            dec.load  = is_load(op);
            dec.store = is_store(op);
            dec.use_a = is_store(op);
            dec.dest  = is_store(op) ? REG_ZERO : ra;
        end else begin
            dec.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/ibox_issue.sv
// Issue stage: decode, operand read with writeback bypass, load scoreboard, one output register.
module ibox_issue
    import ibox_pkg::*;
#(
    parameter bit BYPASS     = 1'b1,
    parameter bit SCOREBOARD = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    output logic [REG_W-1:0] rf_raddr_a,
    output logic [REG_W-1:0] rf_raddr_b,
    input  logic [XLEN-1:0]  rf_rdata_a,
    input  logic [XLEN-1:0]  rf_rdata_b,
    input  logic             wb_en,
    input  logic [REG_W-1:0] wb_addr,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             wb_load,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_a,
    output logic [XLEN-1:0]  out_b,
    output logic [OPC_W-1:0] out_opcode,
    output logic [XLEN-1:0]  out_st_data,
    output logic [REG_W-1:0] out_dest,
    output logic             out_illegal
);

    dec_t             dec;
    logic [XLEN-1:0]  ra_val, rb_val;
    logic [XLEN-1:0]  a_d, b_d, st_d;
    logic [31:0]      sb_q, sb_d;
    logic             pend_a, pend_b, hazard, accept;

    ibox_decode u_decode (
        .op      (in_inst[31:26]),
        .ra      (in_inst[25:21]),
        .lit_sel (in_inst[12]),
        .func    (in_inst[11:5]),
        .rc      (in_inst[4:0]),
        .dec     (dec)
    );

    assign rf_raddr_a = in_inst[25:21];
    assign rf_raddr_b = in_inst[20:16];

    // Source read: r31 is hard zero, otherwise same-cycle writeback wins over the file
    always_comb begin
        ra_val = rf_rdata_a;
        rb_val = rf_rdata_b;
        if (rf_raddr_a == REG_ZERO)
            ra_val = '0;
        else if (BYPASS && wb_en && (wb_addr == rf_raddr_a))
            ra_val = wb_data;
        if (rf_raddr_b == REG_ZERO)
            rb_val = '0;
        else if (BYPASS && wb_en && (wb_addr == rf_raddr_b))
            rb_val = wb_data;
    end

    // Load-use hazard; a load return landing this cycle releases its dependant only when bypassed
    always_comb begin
        pend_a = dec.use_a && (rf_raddr_a != REG_ZERO) && sb_q[rf_raddr_a]
                 && !(BYPASS && wb_en && wb_load && (wb_addr == rf_raddr_a));
        pend_b = dec.use_b && (rf_raddr_b != REG_ZERO) && sb_q[rf_raddr_b]
                 && !(BYPASS && wb_en && wb_load && (wb_addr == rf_raddr_b));
        hazard = SCOREBOARD && (pend_a || pend_b);
    end

    assign in_ready = !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready && !flush;

    // Operand formation per instruction format
    always_comb begin
        a_d  = '0;
        b_d  = '0;
        st_d = '0;
        case (dec.fmt)
            FMT_OPR: begin
                a_d = ra_val;
                b_d = dec.use_lit ? XLEN'(in_inst[20:13]) : rb_val;
            end
            FMT_MEM: begin
                a_d = {{(XLEN-16){in_inst[15]}}, in_inst[15:0]};
                b_d = rb_val;
                if (dec.store)
                    st_d = ra_val;
            end
            default: ;
        endcase
    end

    // Scoreboard next state: clear on load return, then set on load issue so set wins
    always_comb begin
        sb_d = sb_q;
        if (wb_en && wb_load)
            sb_d[wb_addr] = 1'b0;
        if (accept && dec.load && (dec.dest != REG_ZERO))
            sb_d[dec.dest] = 1'b1;
        if (!SCOREBOARD)
            sb_d = '0;
    end

    // Issue register and scoreboard state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            out_a       <= '0;
            out_b       <= '0;
            out_opcode  <= '0;
            out_st_data <= '0;
            out_dest    <= '0;
            out_illegal <= 1'b0;
            sb_q        <= '0;
        end else begin
            out_valid <= accept || (out_valid && !out_ready && !flush);
            if (accept) begin
                out_a       <= a_d;
                out_b       <= b_d;
                out_opcode  <= {in_inst[31:26], dec.func7};
                out_st_data <= st_d;
                out_dest    <= dec.dest;
                out_illegal <= dec.illegal;
            end
            sb_q <= sb_d;
        end
    end

endmodule
